// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
// Address/data typedefs, read-only register map and the clear-sequencer states.
package regfile_pkg;

    typedef logic [3:0]  reg_addr_t;
    typedef logic [15:0] reg_data_t;

    localparam reg_addr_t REG_SP            = 4'hD;
    localparam reg_addr_t REG_SR            = 4'hE;
    localparam reg_addr_t REG_PC            = 4'hF;
    localparam reg_addr_t REG_LAST_WRITABLE = 4'hC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_EXEC = 2'd1,
        GNT_MEM  = 2'd2,
        GNT_DBG  = 2'd3
    } gnt_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes, clear control/status and the register-file write port.
// The arbiter uses the slave modport; the surrounding pipeline uses master.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              exec_valid;
    logic [ADDR_W-1:0] exec_addr;
    logic [DATA_W-1:0] exec_data;
    logic              exec_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              dbg_valid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_ready;

    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;
    logic              ro_violation;

    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              write_en;

    modport slave (
        input  exec_valid, exec_addr, exec_data,
        input  mem_valid, mem_addr, mem_data,
        input  dbg_valid, dbg_addr, dbg_data,
        input  clear_req,
        output exec_ready, mem_ready, dbg_ready,
        output clear_busy, clear_done, ro_violation,
        output write_addr, write_data, write_en
    );

    modport master (
        output exec_valid, exec_addr, exec_data,
        output mem_valid, mem_addr, mem_data,
        output dbg_valid, dbg_addr, dbg_data,
        output clear_req,
        input  exec_ready, mem_ready, dbg_ready,
        input  clear_busy, clear_done, ro_violation,
        input  write_addr, write_data, write_en
    );
endinterface

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks addresses 0..LAST_WRITABLE and asks the arbiter to
// override its mux with a zero-write for each, then pulses done for one cycle.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int              ADDR_W        = 4,
    parameter logic [ADDR_W-1:0] LAST_WRITABLE = REG_LAST_WRITABLE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear_req,
    output logic              o_override,
    output logic [ADDR_W-1:0] o_ov_addr,
    output logic              o_clear_busy,
    output logic              o_clear_done
);
    clr_state_t        r_state;
    clr_state_t        w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_override   = 1'b0;
        o_clear_busy = 1'b0;
        o_clear_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (i_clear_req) w_state_next = CLEAR;
            end
            CLEAR: begin
                o_override   = 1'b1;
                o_clear_busy = 1'b1;
                w_cnt_next   = r_cnt + 1'b1;
                if (r_cnt == LAST_WRITABLE) w_state_next = DONE;
            end
            DONE: begin
                o_clear_busy = 1'b1;
                o_clear_done = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_ov_addr = r_cnt;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single write port of the register file shared by mem load, execute and debug
// writebacks, with a starvation escape for debug and a bank-clear override.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int                DATA_W        = 16,
    parameter int                ADDR_W        = 4,
    parameter logic [ADDR_W-1:0] LAST_WRITABLE = REG_LAST_WRITABLE,
    parameter int                STARVE_LIMIT  = 8
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic              w_override;
    logic [ADDR_W-1:0] w_ov_addr;
    logic              w_clear_busy;
    logic              w_clear_done;
    logic              w_starved;
    logic              w_xfer;
    gnt_t              w_gnt;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    logic [SW-1:0]     r_starve;
    logic              r_en;
    logic              r_ro;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    regfile_clear_seq #(
        .ADDR_W        (ADDR_W),
        .LAST_WRITABLE (LAST_WRITABLE)
    ) u_clear_seq (
        .clock        (clock),
        .reset        (reset),
        .i_clear_req  (bus.clear_req),
        .o_override   (w_override),
        .o_ov_addr    (w_ov_addr),
        .o_clear_busy (w_clear_busy),
        .o_clear_done (w_clear_done)
    );

    assign w_starved = (r_starve == SW'(STARVE_LIMIT));

    // No requester is acked while the sequencer is in CLEAR or DONE.
    always_comb begin
        w_gnt = GNT_NONE;
        if (!w_clear_busy) begin
            if (w_starved && bus.dbg_valid) w_gnt = GNT_DBG;
            else if (bus.mem_valid)         w_gnt = GNT_MEM;
            else if (bus.exec_valid)        w_gnt = GNT_EXEC;
            else if (bus.dbg_valid)         w_gnt = GNT_DBG;
        end
    end

    always_comb begin
        w_sel_addr = bus.exec_addr;
        w_sel_data = bus.exec_data;
        case (w_gnt)
            GNT_MEM: begin
                w_sel_addr = bus.mem_addr;
                w_sel_data = bus.mem_data;
            end
            GNT_DBG: begin
                w_sel_addr = bus.dbg_addr;
                w_sel_data = bus.dbg_data;
            end
            default: ;
        endcase
    end

    assign w_xfer         = (w_gnt != GNT_NONE);
    assign bus.exec_ready = (w_gnt == GNT_EXEC);
    assign bus.mem_ready  = (w_gnt == GNT_MEM);
    assign bus.dbg_ready  = (w_gnt == GNT_DBG);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve <= '0;
        end else if (bus.dbg_valid && (w_gnt != GNT_DBG)) begin
            if (!w_starved) r_starve <= r_starve + 1'b1;
        end else begin
            r_starve <= '0;
        end
    end

    // Read-only targets are acked but turned into a violation pulse, not a write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_en   <= 1'b0;
            r_ro   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_en <= 1'b0;
            r_ro <= 1'b0;
            if (w_override) begin
                r_en   <= 1'b1;
                r_addr <= w_ov_addr;
                r_data <= '0;
            end else if (w_xfer) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
                r_en   <= (w_sel_addr <= LAST_WRITABLE);
                r_ro   <= (w_sel_addr >  LAST_WRITABLE);
            end
        end
    end

    assign bus.write_en     = r_en;
    assign bus.write_addr   = r_addr;
    assign bus.write_data   = r_data;
    assign bus.ro_violation = r_ro;
    assign bus.clear_busy   = w_clear_busy;
    assign bus.clear_done   = w_clear_done;

endmodule
